// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC generator, single-outstanding memory requester
// and a first-word-fall-through queue of {pc, instr} pairs with flush/redirect.
module fetch_queue #(
  parameter int              DEPTH    = 8,
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h00000060
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   instr_read,
  output logic [XLEN-1:0]        instr_mem_address,
  input  logic                   instr_mem_resp,
  input  logic [XLEN-1:0]        instr_mem_rdata,
  input  logic                   deq,
  input  logic                   flush,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   iq_valid,
  output logic [XLEN-1:0]        iq_instr,
  output logic [XLEN-1:0]        iq_pc,
  output logic                   iq_full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] addr_reg, addr_next;
  logic [AW-1:0]   head_reg, head_next;
  logic [AW-1:0]   tail_reg, tail_next;
  logic [AW:0]     count_reg, count_next;
  logic [AW:0]     count_after_deq;
  logic            enq;
  logic            deq_ok;

  logic [XLEN-1:0] pc_ram    [DEPTH];
  logic [XLEN-1:0] instr_ram [DEPTH];

  always_comb begin
    deq_ok          = deq && !flush && (count_reg != '0);
    count_after_deq = count_reg - (AW+1)'(deq_ok);
    state_next      = state_reg;
    pc_next         = pc_reg;
    addr_next       = addr_reg;
    enq             = 1'b0;

    case (state_reg)
      IDLE: begin
        if (flush) begin
          pc_next    = redirect_pc;
          addr_next  = redirect_pc;
          state_next = FETCH;
        end else if (count_after_deq < DEPTH_C) begin
          addr_next  = pc_reg;
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (flush) begin
          pc_next = redirect_pc;
          // Without a response the old request is still in flight; keep its address until it returns.
          if (instr_mem_resp) addr_next = redirect_pc;
          else state_next = DRAIN;
        end else if (instr_mem_resp) begin
          enq       = 1'b1;
          pc_next   = pc_reg + XLEN'(4);
          addr_next = pc_reg + XLEN'(4);
          if (count_after_deq + (AW+1)'(1) >= DEPTH_C) state_next = IDLE;
        end
      end
      DRAIN: begin
        if (flush) pc_next = redirect_pc;
        if (instr_mem_resp) begin
          state_next = FETCH;
          addr_next  = flush ? redirect_pc : pc_reg;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (enq)    tail_next = tail_reg + AW'(1);
      if (deq_ok) head_next = head_reg + AW'(1);
      count_next = count_reg + (AW+1)'(enq) - (AW+1)'(deq_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      addr_reg  <= RESET_PC;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      addr_reg  <= addr_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; emptiness is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_ram[tail_reg]    <= pc_reg;
      instr_ram[tail_reg] <= instr_mem_rdata;
    end
  end

  assign instr_read        = (state_reg != IDLE);
  assign instr_mem_address = addr_reg;
  assign iq_valid          = (count_reg != '0);
  assign iq_full           = (count_reg == DEPTH_C);
  assign count             = count_reg;
  assign iq_pc             = iq_valid ? pc_ram[head_reg]    : '0;
  assign iq_instr          = iq_valid ? instr_ram[head_reg] : '0;

  a_count_bound: assert property (@(posedge clk) disable iff (!rst) count_reg <= DEPTH_C);
  a_full_no_issue: assert property (@(posedge clk) disable iff (!rst) iq_full |-> !instr_read);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a memory responder with configurable latency and
// a scoreboard of expected {pc, instr} entries checked at the queue head every cycle.
module tb_fetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        deq;
  logic        flush;
  logic [31:0] redirect_pc;

  logic        read1, read2, valid1, valid2, full1, full2;
  logic [31:0] addr1, addr2, instr1, instr2, pc1, pc2;
  logic [3:0]  count1;
  logic [1:0]  count2;

  logic        o_read, o_valid, o_full;
  logic [31:0] o_addr, o_instr, o_pc;
  logic [3:0]  o_count;

  int          total = 0;
  int          bad   = 0;
  ent_t        sb[$];
  logic [31:0] req_log[$];
  int          lat = 2;
  int          wait_cnt = 0;
  logic [31:0] req_addr = '0;
  logic        deq_on = 1'b0;
  logic        flush_now = 1'b0;
  logic        flush_on_resp = 1'b0;
  logic        flush_hit = 1'b0;
  logic [31:0] flush_pc = '0;
  logic        wrong = 1'b0;
  logic [31:0] last_pop_pc = '0;

  fetch_queue #(.DEPTH(8), .XLEN(32), .RESET_PC(32'h00000060)) u_dut (
    .clk(clk), .rst(rst),
    .instr_read(read1), .instr_mem_address(addr1),
    .instr_mem_resp(mem_resp & ~sel), .instr_mem_rdata(mem_rdata),
    .deq(deq & ~sel), .flush(flush & ~sel), .redirect_pc(redirect_pc),
    .iq_valid(valid1), .iq_instr(instr1), .iq_pc(pc1), .iq_full(full1), .count(count1)
  );

  fetch_queue #(.DEPTH(2), .XLEN(32), .RESET_PC(32'h00000060)) u_dut2 (
    .clk(clk), .rst(rst),
    .instr_read(read2), .instr_mem_address(addr2),
    .instr_mem_resp(mem_resp & sel), .instr_mem_rdata(mem_rdata),
    .deq(deq & sel), .flush(flush & sel), .redirect_pc(redirect_pc),
    .iq_valid(valid2), .iq_instr(instr2), .iq_pc(pc2), .iq_full(full2), .count(count2)
  );

  assign o_read  = sel ? read2  : read1;
  assign o_addr  = sel ? addr2  : addr1;
  assign o_valid = sel ? valid2 : valid1;
  assign o_instr = sel ? instr2 : instr1;
  assign o_pc    = sel ? pc2    : pc1;
  assign o_full  = sel ? full2  : full1;
  assign o_count = sel ? {2'b00, count2} : count1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check the head against the scoreboard, then drive memory/deq/flush for the next edge.
  task automatic cycle();
    logic resp_v;
    logic fl;
    ent_t e;
    @(negedge clk);
    chk("count", 32'(o_count), 32'(sb.size()));
    chk("valid", 32'(o_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk("head_pc", o_pc, sb[0].pc);
      chk("head_instr", o_instr, sb[0].instr);
    end else begin
      chk("empty_pc", o_pc, 32'h0);
      chk("empty_instr", o_instr, 32'h0);
    end
    resp_v = 1'b0;
    if (o_read) begin
      if (wait_cnt == 0) begin
        req_addr = o_addr;
        req_log.push_back(o_addr);
      end else begin
        chk("addr_hold", o_addr, req_addr);
      end
      if (wait_cnt + 1 >= lat) begin
        resp_v   = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    fl          = flush_now || (flush_on_resp && resp_v);
    mem_resp    = resp_v;
    mem_rdata   = resp_v ? (o_addr ^ 32'hFFFF0000) : 32'h0;
    flush       = fl;
    redirect_pc = flush_pc;
    deq         = deq_on;
    if (fl) begin
      sb.delete();
      wrong     = o_read && !resp_v;
      flush_now = 1'b0;
      if (flush_on_resp && resp_v) begin
        flush_on_resp = 1'b0;
        flush_hit     = 1'b1;
      end
      $display("flush to %h", flush_pc);
    end else begin
      if (deq_on && sb.size() != 0) begin
        last_pop_pc = o_pc;
        void'(sb.pop_front());
        $display("deq pc=%h instr=%h", o_pc, o_instr);
      end
      if (resp_v) begin
        if (wrong) begin
          wrong = 1'b0;
          $display("drop wrong-path addr=%h", o_addr);
        end else begin
          e.pc    = o_addr;
          e.instr = o_addr ^ 32'hFFFF0000;
          sb.push_back(e);
          $display("enq pc=%h instr=%h", e.pc, e.instr);
        end
      end
    end
  endtask

  task automatic wait_count(input int n, input int bound);
    for (int i = 0; i < bound && int'(o_count) != n; i++) cycle();
    chk("wait_count", 32'(o_count), 32'(n));
  endtask

  task automatic bench_reset_state();
    mem_resp = 1'b0;
    deq      = 1'b0;
    flush    = 1'b0;
    sb.delete();
    req_log.delete();
    wait_cnt = 0;
    wrong    = 1'b0;
  endtask

  initial begin
    rst = 1'b0; sel = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
    deq = 1'b0; flush = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_read", 32'(o_read), 32'h0);
    chk("rst_addr", o_addr, 32'h60);
    chk("rst_count", 32'(o_count), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_full", 32'(o_full), 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_instr", o_instr, 32'h0);
    rst = 1'b1;

    // Fill from reset with no consumer
    lat = 2;
    cycle();
    chk("first_read", 32'(o_read), 32'h1);
    chk("first_addr", o_addr, 32'h60);
    wait_count(8, 60);
    chk("fill_full", 32'(o_full), 32'h1);
    chk("fill_read", 32'(o_read), 32'h0);

    // Pop three from a full queue and refill
    req_log.delete();
    deq_on = 1'b1;
    cycle(); chk("pop0_pc", last_pop_pc, 32'h60);
    cycle(); chk("pop1_pc", last_pop_pc, 32'h64);
    cycle(); chk("pop2_pc", last_pop_pc, 32'h68);
    deq_on = 1'b0;
    wait_count(8, 40);
    chk("refill_reqs", 32'(req_log.size()), 32'd3);
    chk("refill_first", (req_log.size() > 0) ? req_log[0] : 32'hFFFFFFFF, 32'h80);
    chk("refill_last", (req_log.size() > 2) ? req_log[2] : 32'hFFFFFFFF, 32'h88);

    // Flush into DRAIN with a slow memory
    deq_on = 1'b1;
    cycle();
    deq_on = 1'b0;
    req_log.delete();
    lat = 4;
    cycle();
    cycle();
    flush_now = 1'b1;
    flush_pc  = 32'h200;
    cycle();
    cycle();
    chk("drain_read", 32'(o_read), 32'h1);
    chk("drain_addr", o_addr, (req_log.size() > 0) ? req_log[0] : 32'hFFFFFFFF);
    wait_count(1, 20);
    chk("redirect_addr", (req_log.size() > 1) ? req_log[1] : 32'hFFFFFFFF, 32'h200);

    // Flush coinciding with a response
    flush_on_resp = 1'b1;
    flush_pc      = 32'h400;
    for (int i = 0; i < 20 && !flush_hit; i++) cycle();
    chk("flush_resp_hit", 32'(flush_hit), 32'h1);
    cycle();
    chk("fr_addr", o_addr, 32'h400);
    chk("fr_read", 32'(o_read), 32'h1);
    chk("fr_valid", 32'(o_valid), 32'h0);

    // Stream with a consumer, then reset mid-request with 5 queued
    lat = 2;
    deq_on = 1'b1;
    repeat (10) cycle();
    deq_on = 1'b0;
    wait_count(5, 60);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_read", 32'(o_read), 32'h0);
    chk("mid_rst_count", 32'(o_count), 32'h0);
    chk("mid_rst_addr", o_addr, 32'h60);
    chk("mid_rst_valid", 32'(o_valid), 32'h0);
    bench_reset_state();
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("refetch_read", 32'(o_read), 32'h1);
    chk("refetch_addr", o_addr, 32'h60);
    wait_count(2, 20);
    chk("refetch_first", (req_log.size() > 0) ? req_log[0] : 32'hFFFFFFFF, 32'h60);

    // DEPTH=2 instance: continuous consumer across pointer wrap
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b1;
    bench_reset_state();
    lat = 2;
    deq_on = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      chk("d2_count_le1", 32'(o_count <= 4'd1), 32'h1);
    end
    deq_on = 1'b0;
    wait_count(2, 20);
    chk("d2_full", 32'(o_full), 32'h1);
    chk("d2_read", 32'(o_read), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
